iq_sweep_controller: RTL
========================

# iq_sweep_controller

Frequency-sweep sequencer for one `IQModule` instance. It steps the module's NCO phase increment from a start value by a fixed step, waits a settle interval at each step, and averages 2^ACC_LOG2 filtered I/Q samples. Each averaged point is presented on a valid/ready result port. It sits between the physical controls/host logic and the `IQModule` `phaseInc` input, replacing the hard-wired increments, and runs in the same `CLK` domain.

## Interface

Parameters:
- `PHASE_W`, 32: phase increment width; matches `IQModule.phaseInc`.
- `DATA_W`, 14: signed I/Q sample width.
- `STEP_W`, 16: step counter and index width.
- `SETTLE_CYCLES`, 1024: cycles to wait after each increment change; must be ≥1.
- `ACC_LOG2`, 4: log2 of the samples averaged per point; range 0..8.

Ports:
- `CLK` in 1: system clock; the IQ module clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request; honoured only in IDLE.
- `abort` in 1: return to IDLE from any state.
- `cfg_start_inc` in PHASE_W: first phase increment.
- `cfg_step_inc` in PHASE_W: increment added per step (unsigned, modular).
- `cfg_num_steps` in STEP_W: number of points to measure.
- `phase_inc` out PHASE_W: drives `IQModule.phaseInc`.
- `i_in`, `q_in` in DATA_W signed: `IQModule` I and Q outputs.
- `filt_valid` in 1: a new filtered I/Q sample is present this cycle.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts the result.
- `res_i`, `res_q` out DATA_W signed: averaged I and Q.
- `res_idx` out STEP_W: step index of the result, 0-based.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a sweep completes normally.

## Operation

- States:
  - IDLE: `busy`=0.
  - SETTLE: a countdown runs.
  - ACCUM: sums samples.
  - OUTPUT: holds `res_valid`.
- Transition on `start` in IDLE:
  - Latch `cfg_*` into internal registers. Config changes mid-sweep have no effect.
  - If `cfg_num_steps`==0: pulse `done` the next cycle, stay in IDLE, produce no results.
  - Otherwise: `phase_inc` ← `cfg_start_inc`, step index ← 0, settle counter ← SETTLE_CYCLES−1, enter SETTLE.
- SETTLE: decrement each cycle. Leave for ACCUM when the count is 0 (exactly SETTLE_CYCLES cycles in SETTLE). Clear the accumulators and the sample count on entry to ACCUM.
- ACCUM:
  - On each cycle with `filt_valid`=1, add the sign-extended `i_in`/`q_in` into DATA_W+ACC_LOG2-bit signed accumulators and increment the sample count.
  - Samples with `filt_valid`=0 are ignored.
  - After the 2^ACC_LOG2-th sample, register `res_i`/`res_q` = accumulator >>> ACC_LOG2 (arithmetic shift, truncate toward −∞) and `res_idx` = step index, then enter OUTPUT.
- OUTPUT: `res_valid`=1. `res_i`, `res_q`, `res_idx` and `phase_inc` stay stable until the handshake.
  - On `res_valid && res_ready`, if step index == num_steps−1: go to IDLE and pulse `done` the same cycle.
  - Otherwise: `phase_inc` ← `phase_inc` + step (mod 2^PHASE_W, wraps silently), step index +1, reload the settle counter, enter SETTLE.
- `abort`, in any state: IDLE next cycle. Drop `res_valid`, no `done`. `phase_inc` holds its last value. `abort` has priority over `start` and the handshake.
- `start` while busy: ignored.
- Overflow: none possible. The accumulator width holds 2^ACC_LOG2 full-scale samples.

## Timing

- Reset values: state IDLE; `phase_inc`=0; `res_valid`=0, `done`=0, `busy`=0; `res_i`=`res_q`=0; `res_idx`=0.
- `start` at cycle t:
  - `phase_inc` = start value and `busy`=1 at t+1.
  - First ACCUM cycle at t+1+SETTLE_CYCLES.
- Last accumulated sample at cycle s: `res_valid`=1 at s+1.
- Handshake at cycle h: `res_valid`=0 and the new `phase_inc` at h+1. `done`=1 at h+1 when it is the final step.
- `filt_valid` and the accumulation in a single cycle both register at the same clock edge. Zero-latency accumulation: sample k is counted at the edge of its cycle.
- All outputs are registered; no combinational input-to-output paths.

## Structure

- Package `iq_sweep_pkg`: state enum (`S_IDLE`, `S_SETTLE`, `S_ACCUM`, `S_OUTPUT`) and default width constants.
- One sub-module, `iq_avg_accum`: dual signed accumulator with clear, enable, sample counter, `full` flag and shifted outputs; parameterised by DATA_W and ACC_LOG2.
- The top level holds the FSM, the settle counter, the phase register and the result registers.

## Test plan

Bench parameters: SETTLE_CYCLES=4, ACC_LOG2=2.

1. Sweep `cfg_start_inc`=343597384, step=343597384, steps=3, `filt_valid` always 1, I=100, Q=−100, `res_ready`=1.
   - `res_idx` 0,1,2 with `phase_inc` 343597384, 687194768, 1030792152.
   - Each `res_i`=100, `res_q`=−100.
   - `done` pulses once after the third handshake.
2. Averaging and rounding: I samples 1,2,2,2 → `res_i`=1; Q samples −1,−2,−2,−2 → `res_q`=−2. Samples with `filt_valid` every third cycle are still averaged correctly.
3. Backpressure: hold `res_ready`=0 for 10 cycles in OUTPUT → `res_valid`, data and `phase_inc` remain stable, and no further `phase_inc` step occurs.
4. Wrap-around: start=0xFFFFFFF0, step=0x20, steps=2 → second `phase_inc`=0x00000010.
5. Edge cases:
   - `cfg_num_steps`=0 → `done` at t+1, `busy` stays 0.
   - `start` pulsed during SETTLE is ignored.
   - `abort` in ACCUM → IDLE next cycle, no `res_valid`, no `done`.
6. `reset` asserted in OUTPUT → all outputs at reset values next cycle. A new `start` then sweeps normally.

Source files
------------

// File: rtl/iq_sweep_pkg.sv
// Shared state encoding, default widths and sizing helper for the IQ frequency-sweep controller.
package iq_sweep_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_ACCUM  = 2'd2,
        S_OUTPUT = 2'd3
    } sweep_state_t;

    localparam int DEF_PHASE_W       = 32;
    localparam int DEF_DATA_W        = 14;
    localparam int DEF_STEP_W        = 16;
    localparam int DEF_SETTLE_CYCLES = 1024;
    localparam int DEF_ACC_LOG2      = 4;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iq_sweep_if.sv
// Host/IQModule-facing bundle of the sweep controller: config, control, samples, phase and results.
// Host side owns start/abort/cfg/samples/res_ready; the controller owns phase, results and status.
interface iq_sweep_if
    import iq_sweep_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int STEP_W  = DEF_STEP_W
);
    logic                     start;
    logic                     abort;
    logic [PHASE_W-1:0]       cfg_start_inc;
    logic [PHASE_W-1:0]       cfg_step_inc;
    logic [STEP_W-1:0]        cfg_num_steps;
    logic [PHASE_W-1:0]       phase_inc;
    logic signed [DATA_W-1:0] i_in;
    logic signed [DATA_W-1:0] q_in;
    logic                     filt_valid;
    logic                     res_valid;
    logic                     res_ready;
    logic signed [DATA_W-1:0] res_i;
    logic signed [DATA_W-1:0] res_q;
    logic [STEP_W-1:0]        res_idx;
    logic                     busy;
    logic                     done;

    modport master (
        output start, abort, cfg_start_inc, cfg_step_inc, cfg_num_steps,
        output i_in, q_in, filt_valid, res_ready,
        input  phase_inc, res_valid, res_i, res_q, res_idx, busy, done
    );

    modport slave (
        input  start, abort, cfg_start_inc, cfg_step_inc, cfg_num_steps,
        input  i_in, q_in, filt_valid, res_ready,
        output phase_inc, res_valid, res_i, res_q, res_idx, busy, done
    );
endinterface

// File: rtl/iq_avg_accum.sv
// Dual signed I/Q accumulator averaging 2**ACC_LOG2 samples; o_full/o_avg_* include the current enabled sample.
// Zero-latency accumulate on i_en; no backpressure, caller gates i_en.
module iq_avg_accum #(
    parameter int DATA_W   = 14,
    parameter int ACC_LOG2 = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clr,
    input  logic                     i_en,
    input  logic signed [DATA_W-1:0] i_i,
    input  logic signed [DATA_W-1:0] i_q,
    output logic                     o_full,
    output logic signed [DATA_W-1:0] o_avg_i,
    output logic signed [DATA_W-1:0] o_avg_q
);
    localparam int SUM_W = DATA_W + ACC_LOG2;
    localparam int CNT_W = ACC_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << ACC_LOG2) - 1);

    logic signed [SUM_W-1:0] r_acc_i;
    logic signed [SUM_W-1:0] r_acc_q;
    logic [CNT_W-1:0]        r_cnt;
    logic signed [SUM_W-1:0] w_sum_i;
    logic signed [SUM_W-1:0] w_sum_q;

    // Running sum including this cycle's sample, so the average is ready at the last sample's edge.
    assign w_sum_i = r_acc_i + SUM_W'(i_i);
    assign w_sum_q = r_acc_q + SUM_W'(i_q);
    assign o_full  = i_en && (r_cnt == LAST_CNT);
    assign o_avg_i = DATA_W'(w_sum_i >>> ACC_LOG2);
    assign o_avg_q = DATA_W'(w_sum_q >>> ACC_LOG2);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_acc_i <= '0;
            r_acc_q <= '0;
            r_cnt   <= '0;
        end else if (i_en) begin
            r_acc_i <= w_sum_i;
            r_acc_q <= w_sum_q;
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/iq_sweep_controller.sv
// Steps the NCO phase increment, settles, averages I/Q and emits one result per step; all outputs registered.
// Result held on res_valid until res_ready; phase does not advance while the result is stalled.
module iq_sweep_controller
    import iq_sweep_pkg::*;
#(
    parameter int PHASE_W       = DEF_PHASE_W,
    parameter int DATA_W        = DEF_DATA_W,
    parameter int STEP_W        = DEF_STEP_W,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int ACC_LOG2      = DEF_ACC_LOG2
) (
    input logic       CLK,
    input logic       reset,
    iq_sweep_if.slave bus
);
    localparam int SCNT_W = cnt_width(SETTLE_CYCLES);
    localparam logic [SCNT_W-1:0] SETTLE_RELOAD = SCNT_W'(SETTLE_CYCLES - 1);

    sweep_state_t             r_state;
    sweep_state_t             w_next_state;
    logic [SCNT_W-1:0]        r_settle_cnt;
    logic [PHASE_W-1:0]       r_phase_inc;
    logic [PHASE_W-1:0]       r_step_inc;
    logic [STEP_W-1:0]        r_num_steps;
    logic [STEP_W-1:0]        r_step_idx;
    logic signed [DATA_W-1:0] r_res_i;
    logic signed [DATA_W-1:0] r_res_q;
    logic [STEP_W-1:0]        r_res_idx;
    logic                     r_done;

    logic                     w_settle_zero;
    logic                     w_last_step;
    logic                     w_acc_en;
    logic                     w_full;
    logic signed [DATA_W-1:0] w_avg_i;
    logic signed [DATA_W-1:0] w_avg_q;
    logic                     w_cfg_load;
    logic                     w_empty_sweep;
    logic                     w_sweep_begin;
    logic                     w_settle_dec;
    logic                     w_acc_clr;
    logic                     w_capture;
    logic                     w_step_next;
    logic                     w_finish;

    assign w_settle_zero = (r_settle_cnt == '0);
    assign w_last_step   = (r_step_idx == r_num_steps - STEP_W'(1));
    assign w_acc_en      = (r_state == S_ACCUM) && bus.filt_valid;

    iq_avg_accum #(
        .DATA_W   (DATA_W),
        .ACC_LOG2 (ACC_LOG2)
    ) u_accum (
        .clk     (CLK),
        .rst     (reset),
        .i_clr   (w_acc_clr),
        .i_en    (w_acc_en),
        .i_i     (bus.i_in),
        .i_q     (bus.q_in),
        .o_full  (w_full),
        .o_avg_i (w_avg_i),
        .o_avg_q (w_avg_q)
    );

    always_ff @(posedge CLK) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (bus.start && bus.cfg_num_steps != '0) w_next_state = S_SETTLE;
            S_SETTLE: if (w_settle_zero) w_next_state = S_ACCUM;
            S_ACCUM:  if (w_full) w_next_state = S_OUTPUT;
            S_OUTPUT: if (bus.res_ready) w_next_state = w_last_step ? S_IDLE : S_SETTLE;
            default:  w_next_state = S_IDLE;
        endcase
        if (bus.abort) w_next_state = S_IDLE;
    end

    // Abort suppresses every datapath update, so phase and results keep their last values.
    always_comb begin
        w_cfg_load    = 1'b0;
        w_empty_sweep = 1'b0;
        w_sweep_begin = 1'b0;
        w_settle_dec  = 1'b0;
        w_acc_clr     = 1'b0;
        w_capture     = 1'b0;
        w_step_next   = 1'b0;
        w_finish      = 1'b0;
        if (!bus.abort) begin
            case (r_state)
                S_IDLE: begin
                    w_cfg_load    = bus.start;
                    w_empty_sweep = bus.start && (bus.cfg_num_steps == '0);
                    w_sweep_begin = bus.start && (bus.cfg_num_steps != '0);
                end
                S_SETTLE: begin
                    w_settle_dec = !w_settle_zero;
                    w_acc_clr    = w_settle_zero;
                end
                S_ACCUM:  w_capture = w_full;
                S_OUTPUT: begin
                    w_finish    = bus.res_ready && w_last_step;
                    w_step_next = bus.res_ready && !w_last_step;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_settle_cnt <= '0;
            r_phase_inc  <= '0;
            r_step_inc   <= '0;
            r_num_steps  <= '0;
            r_step_idx   <= '0;
            r_res_i      <= '0;
            r_res_q      <= '0;
            r_res_idx    <= '0;
            r_done       <= 1'b0;
        end else begin
            r_done <= w_empty_sweep || w_finish;
            if (w_cfg_load) begin
                r_step_inc  <= bus.cfg_step_inc;
                r_num_steps <= bus.cfg_num_steps;
            end
            if (w_sweep_begin) begin
                r_phase_inc  <= bus.cfg_start_inc;
                r_step_idx   <= '0;
                r_settle_cnt <= SETTLE_RELOAD;
            end
            if (w_settle_dec) r_settle_cnt <= r_settle_cnt - SCNT_W'(1);
            if (w_capture) begin
                r_res_i   <= w_avg_i;
                r_res_q   <= w_avg_q;
                r_res_idx <= r_step_idx;
            end
            if (w_step_next) begin
                r_phase_inc  <= r_phase_inc + r_step_inc;
                r_step_idx   <= r_step_idx + STEP_W'(1);
                r_settle_cnt <= SETTLE_RELOAD;
            end
        end
    end

    assign bus.phase_inc = r_phase_inc;
    assign bus.res_valid = (r_state == S_OUTPUT);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = r_done;
    assign bus.res_i     = r_res_i;
    assign bus.res_q     = r_res_q;
    assign bus.res_idx   = r_res_idx;
endmodule
